fifo_rd_streamer: RTL

//  Read-side consumer for the async FIFO (rclk domain). Drains words via rinc/rempty/rdata
//  and presents them downstream as a valid/ready stream. A 3-entry skid buffer absorbs the
//  1-cycle FIFO read latency, so draining runs at full rate with no combinational path

---
 rtl/fifo_rd_streamer_if.sv | 30 +++
 rtl/fifo_rd_streamer.sv | 106 ++++++++++
 2 files changed

// File: rtl/fifo_rd_streamer_if.sv
// FIFO read port plus downstream valid/ready stream, bundled for the read-side streamer.
// The master side is the streamer; the slave side is the FIFO and the sink.
interface fifo_rd_streamer_if #(
  parameter int DW = 8
) ();
  logic          rinc;
  logic          rempty;
  logic [DW-1:0] rdata;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;

  modport master (
    output rinc,
    input  rempty,
    input  rdata,
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  rinc,
    output rempty,
    output rdata,
    input  m_valid,
    input  m_data,
    output m_ready
  );
endinterface

// File: rtl/fifo_rd_streamer.sv
// Drains an async FIFO read port into a valid/ready stream through a 3-entry skid buffer
// that hides the one-cycle FIFO read latency and keeps m_ready off the rinc path.
module fifo_rd_streamer #(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic                 rclk,
  input  logic                 rst_n,
  input  logic                 en,
  fifo_rd_streamer_if.master   bus,
  output logic [CNT_W-1:0]     pop_cnt,
  output logic [CNT_W-1:0]     xfer_cnt,
  output logic                 idle
);

  logic [1:0]    occ_reg, occ_next;
  logic          inflight_reg;
  logic [1:0]    head_reg, head_next;
  logic [1:0]    tail_reg, tail_next;
  logic [DW-1:0] buf_reg [3];
  logic [CNT_W-1:0] pop_cnt_reg, xfer_cnt_reg;

  logic [2:0]    load;
  logic          pop;
  logic          capture;
  logic          xfer;
  logic          m_valid_int;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Reserve a slot for the in-flight word so a landing word always has room.
  assign load        = {1'b0, occ_reg} + {2'b0, inflight_reg};
  assign bus.rinc    = rst_n & en & ~bus.rempty & (load < 3'd3);
  assign pop         = bus.rinc;
  assign capture     = inflight_reg;
  assign m_valid_int = (occ_reg != 2'd0);
  assign xfer        = m_valid_int & bus.m_ready;

  assign bus.m_valid = m_valid_int;
  assign pop_cnt     = pop_cnt_reg;
  assign xfer_cnt    = xfer_cnt_reg;
  assign idle        = (occ_reg == 2'd0) & ~inflight_reg;

  always_comb begin
    occ_next  = occ_reg;
    head_next = head_reg;
    tail_next = tail_reg;
    if (capture) begin
      tail_next = ptr_inc(tail_reg);
    end
    if (xfer) begin
      head_next = ptr_inc(head_reg);
    end
    case ({capture, xfer})
      2'b10:   occ_next = occ_reg + 2'd1;
      2'b01:   occ_next = occ_reg - 2'd1;
      default: occ_next = occ_reg;
    endcase
  end

  always_comb begin
    case (head_reg)
      2'd1:    bus.m_data = buf_reg[1];
      2'd2:    bus.m_data = buf_reg[2];
      default: bus.m_data = buf_reg[0];
    endcase
  end

  always_ff @(posedge rclk) begin
    if (!rst_n) begin
      occ_reg      <= 2'd0;
      inflight_reg <= 1'b0;
      head_reg     <= 2'd0;
      tail_reg     <= 2'd0;
      pop_cnt_reg  <= '0;
      xfer_cnt_reg <= '0;
    end else begin
      occ_reg      <= occ_next;
      inflight_reg <= pop;
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      if (pop) begin
        pop_cnt_reg <= pop_cnt_reg + 1'b1;
      end
      if (xfer) begin
        xfer_cnt_reg <= xfer_cnt_reg + 1'b1;
      end
    end
  end

  // Entries are cleared on reset so m_data reads zero until the first word lands.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_entry
      always_ff @(posedge rclk) begin
        if (!rst_n) begin
          buf_reg[gi] <= '0;
        end else if (capture && (tail_reg == 2'(gi))) begin
          buf_reg[gi] <= bus.rdata;
        end
      end
    end
  endgenerate

endmodule
